// File: rtl/fifo_pop_dispatch_pkg.sv
// Shared constants and the tagged output word for the pop/dispatch stage.
// The tagged word carries the source queue id alongside the FIFO data.
package fifo_pop_dispatch_pkg;
  localparam int NUM_Q      = 4;
  localparam int ID_W       = 2;
  localparam int DATA_W_DEF = 6;

  typedef struct packed {
    logic [ID_W-1:0]       cls;
    logic [DATA_W_DEF-1:0] data;
  } tag_word_t;
endpackage

// File: rtl/fifo_pop_dispatch_pop_out_buf.sv
// Small synchronous FIFO holding dispatched words: one-cycle write, head visible next cycle.
// No internal backpressure; pushes when full and pops when empty are ignored.
module pop_out_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap at DEPTH, which need not be a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_pop_dispatch.sv
// Pops granted queues, captures the returned word a cycle later and dispatches it tagged with its class.
// Grant-to-valid_out latency 2; credits stop grants when in-flight plus buffered words reach OUT_DEPTH.
import fifo_pop_dispatch_pkg::*;

module fifo_pop_dispatch #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int OUT_DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_W-1:0]         id,
  input  logic                    id_valid,
  output logic                    id_ready,
  input  logic [NUM_Q-1:0]        empty,
  output logic [NUM_Q-1:0]        pop,
  input  logic [NUM_Q*DATA_W-1:0] fifo_data,
  output logic [DATA_W-1:0]       data_out,
  output logic [ID_W-1:0]         class_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    drop
);
  localparam int CW = $clog2(OUT_DEPTH + 1);

  logic [CW-1:0]   cnt;
  logic            grant;
  logic            accept;
  logic            xfer;
  logic            inflight_vld;
  logic [ID_W-1:0] inflight_id;
  tag_word_t       buf_in;
  tag_word_t       buf_head;
  logic            buf_empty;
  logic            unused_buf_full;

  // Credit check uses only registered state, so ready_in never reaches id_ready.
  assign id_ready = reset & (cnt < CW'(OUT_DEPTH));
  assign grant    = id_valid & id_ready;
  assign accept   = grant & ~empty[id];

  always_comb begin
    pop = '0;
    if (accept) pop[id] = 1'b1;
  end

  assign buf_in.cls  = inflight_id;
  assign buf_in.data = fifo_data[inflight_id*DATA_W +: DATA_W];

  assign valid_out = ~buf_empty;
  assign data_out  = buf_head.data;
  assign class_out = buf_head.cls;
  assign xfer      = valid_out & ready_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_vld <= 1'b0;
      inflight_id  <= '0;
      drop         <= 1'b0;
      cnt          <= '0;
    end else begin
      inflight_vld <= accept;
      if (accept) inflight_id <= id;
      drop <= grant & empty[id];
      if (accept && !xfer) begin
        cnt <= cnt + 1'b1;
      end else if (!accept && xfer) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  pop_out_buf #(
    .WIDTH($bits(tag_word_t)),
    .DEPTH(OUT_DEPTH)
  ) u_out_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight_vld),
    .push_data(buf_in),
    .pop      (xfer),
    .head     (buf_head),
    .full     (unused_buf_full),
    .empty    (buf_empty)
  );
endmodule

// File: tb/tb_fifo_pop_dispatch.sv
// Directed vector table, hand-written reset sequence, then randomized traffic against a queue-based model.
module tb_fifo_pop_dispatch;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  id;
  logic        id_valid;
  logic        id_ready;
  logic [3:0]  empty;
  logic [3:0]  pop;
  logic [23:0] fifo_data;
  logic [5:0]  data_out;
  logic [1:0]  class_out;
  logic        valid_out;
  logic        ready_in;
  logic        drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_pop_dispatch dut (
    .clk      (clk),
    .reset    (reset),
    .id       (id),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .empty    (empty),
    .pop      (pop),
    .fifo_data(fifo_data),
    .data_out (data_out),
    .class_out(class_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .drop     (drop)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  id;
    logic        idv;
    logic [3:0]  emp;
    logic [23:0] fd;
    logic        rdy;
    logic        e_idr;
    logic [3:0]  e_pop;
    logic        e_v;
    logic [5:0]  e_dat;
    logic [1:0]  e_cls;
    logic        e_drop;
  } vec_t;

  typedef struct {
    logic [1:0] cls;
    logic [5:0] data;
    int         avail;
  } pend_t;

  vec_t  tv[$];
  pend_t pend[$];

  function automatic logic [23:0] pack4(logic [5:0] a0, logic [5:0] a1, logic [5:0] a2, logic [5:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(logic rst, logic [1:0] i, logic idv, logic [3:0] emp, logic [23:0] fd,
                              logic rdy, logic e_idr, logic [3:0] e_pop, logic e_v, logic [5:0] e_dat,
                              logic [1:0] e_cls, logic e_drop);
    vec_t v;
    v.rst = rst; v.id = i; v.idv = idv; v.emp = emp; v.fd = fd; v.rdy = rdy;
    v.e_idr = e_idr; v.e_pop = e_pop; v.e_v = e_v; v.e_dat = e_dat; v.e_cls = e_cls; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; id = v.id; id_valid = v.idv; empty = v.emp; fifo_data = v.fd; ready_in = v.rdy;
    #1;
    check({tag, ".id_ready"}, id_ready, v.e_idr);
    check({tag, ".pop"}, pop, v.e_pop);
    check({tag, ".valid_out"}, valid_out, v.e_v);
    check({tag, ".drop"}, drop, v.e_drop);
    if (v.e_v) begin
      check({tag, ".data_out"}, data_out, v.e_dat);
      check({tag, ".class_out"}, class_out, v.e_cls);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] sg, rr, f2;
    logic        exp_idr, exp_v, exp_drop, acc, drop_m;
    logic [3:0]  exp_pop;
    int          t;

    sg = pack4(6'h00, 6'h00, 6'h2A, 6'h00);
    rr = pack4(6'h10, 6'h11, 6'h12, 6'h13);
    f2 = pack4(6'h00, 6'h21, 6'h00, 6'h00);

    // reset row
    tv.push_back(mk(0, 2, 1, 4'b0000, sg, 1, 0, 4'b0000, 0, 0, 0, 0));
    // single grant
    tv.push_back(mk(1, 2, 1, 4'b0000, sg, 1, 1, 4'b0100, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 0, 4'b0000, sg, 1, 1, 4'b0000, 0, 0, 0, 0));
    tv.push_back(mk(1, 3, 0, 4'b0000, sg, 1, 1, 4'b0000, 1, 6'h2A, 2, 0));
    tv.push_back(mk(1, 0, 0, 4'b0000, sg, 1, 1, 4'b0000, 0, 0, 0, 0));
    // round-robin stream
    tv.push_back(mk(1, 0, 1, 4'b0000, rr, 1, 1, 4'b0001, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 1, 4'b0000, rr, 1, 1, 4'b0010, 0, 0, 0, 0));
    tv.push_back(mk(1, 2, 1, 4'b0000, rr, 1, 1, 4'b0100, 1, 6'h10, 0, 0));
    tv.push_back(mk(1, 3, 1, 4'b0000, rr, 1, 1, 4'b1000, 1, 6'h11, 1, 0));
    tv.push_back(mk(1, 0, 0, 4'b0000, rr, 1, 1, 4'b0000, 1, 6'h12, 2, 0));
    tv.push_back(mk(1, 0, 0, 4'b0000, rr, 1, 1, 4'b0000, 1, 6'h13, 3, 0));
    tv.push_back(mk(1, 0, 0, 4'b0000, rr, 1, 1, 4'b0000, 0, 0, 0, 0));
    // backpressure, then drain with a grant taken in the same cycle as a transfer
    tv.push_back(mk(1, 0, 1, 4'b0000, rr, 0, 1, 4'b0001, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 1, 4'b0000, rr, 0, 1, 4'b0010, 0, 0, 0, 0));
    tv.push_back(mk(1, 2, 1, 4'b0000, rr, 0, 1, 4'b0100, 1, 6'h10, 0, 0));
    tv.push_back(mk(1, 3, 1, 4'b0000, rr, 0, 0, 4'b0000, 1, 6'h10, 0, 0));
    tv.push_back(mk(1, 3, 1, 4'b0000, rr, 1, 0, 4'b0000, 1, 6'h10, 0, 0));
    tv.push_back(mk(1, 3, 1, 4'b0000, rr, 1, 1, 4'b1000, 1, 6'h11, 1, 0));
    tv.push_back(mk(1, 0, 0, 4'b0000, rr, 1, 1, 4'b0000, 1, 6'h12, 2, 0));
    tv.push_back(mk(1, 0, 0, 4'b0000, rr, 1, 1, 4'b0000, 1, 6'h13, 3, 0));
    tv.push_back(mk(1, 0, 0, 4'b0000, rr, 1, 1, 4'b0000, 0, 0, 0, 0));
    // empty grant; empty clears the next cycle but the sampled value already decided
    tv.push_back(mk(1, 1, 1, 4'b0010, rr, 1, 1, 4'b0000, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 0, 4'b0000, rr, 1, 1, 4'b0000, 0, 0, 0, 1));
    tv.push_back(mk(1, 1, 0, 4'b0000, rr, 1, 1, 4'b0000, 0, 0, 0, 0));
    // other queues empty, granted one is not
    tv.push_back(mk(1, 2, 1, 4'b1011, sg, 1, 1, 4'b0100, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 4'b1111, sg, 1, 1, 4'b0000, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 4'b1111, sg, 1, 1, 4'b0000, 1, 6'h2A, 2, 0));
    tv.push_back(mk(1, 0, 0, 4'b0000, sg, 1, 1, 4'b0000, 0, 0, 0, 0));

    reset = 1'b0; id = '0; id_valid = 1'b0; empty = '0; fifo_data = '0; ready_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst.pop", pop, 4'b0000);
    check("rst.valid_out", valid_out, 1'b0);
    check("rst.drop", drop, 1'b0);
    check("rst.data_out", data_out, 6'h00);
    check("rst.class_out", class_out, 2'd0);
    check("rst.id_ready", id_ready, 1'b0);

    for (int i = 0; i < tv.size(); i++) apply(tv[i], $sformatf("vec%0d", i));

    // asynchronous reset with two words buffered and one in flight
    apply(mk(1, 0, 1, 4'b0000, rr, 0, 1, 4'b0001, 0, 0, 0, 0), "mr0");
    apply(mk(1, 1, 1, 4'b0000, rr, 0, 1, 4'b0010, 0, 0, 0, 0), "mr1");
    apply(mk(1, 2, 1, 4'b0000, rr, 0, 1, 4'b0100, 1, 6'h10, 0, 0), "mr2");
    @(posedge clk);
    #2;
    id = 2'd3; id_valid = 1'b1; reset = 1'b0;
    #1;
    check("mr.valid_out", valid_out, 1'b0);
    check("mr.pop", pop, 4'b0000);
    check("mr.id_ready", id_ready, 1'b0);
    check("mr.data_out", data_out, 6'h00);
    apply(mk(1, 1, 1, 4'b0000, f2, 1, 1, 4'b0010, 0, 0, 0, 0), "mr3");
    apply(mk(1, 0, 0, 4'b0000, f2, 1, 1, 4'b0000, 0, 0, 0, 0), "mr4");
    apply(mk(1, 0, 0, 4'b0000, f2, 1, 1, 4'b0000, 1, 6'h21, 1, 0), "mr5");
    apply(mk(1, 0, 0, 4'b0000, f2, 1, 1, 4'b0000, 0, 0, 0, 0), "mr6");
    apply(mk(1, 0, 0, 4'b0000, f2, 1, 1, 4'b0000, 0, 0, 0, 0), "mr7");

    // randomized traffic against a timeline model: each accepted word is due at accept+2
    drop_m = 1'b0;
    pend.delete();
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      reset     = (t == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      id        = 2'($urandom_range(0, 3));
      id_valid  = ($urandom_range(0, 3) != 0);
      empty     = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      fifo_data = 24'($urandom);
      ready_in  = ($urandom_range(0, 3) != 0);
      acc = 1'b0;
      if (!reset) begin
        pend.delete();
        drop_m = 1'b0;
        exp_idr = 1'b0; exp_pop = '0; exp_v = 1'b0; exp_drop = 1'b0;
      end else begin
        foreach (pend[k]) if (pend[k].avail == t + 1) pend[k].data = fifo_data[pend[k].cls*6 +: 6];
        exp_idr  = (pend.size() < 3);
        exp_v    = (pend.size() > 0) && (pend[0].avail <= t);
        exp_drop = drop_m;
        acc      = id_valid && exp_idr && !empty[id];
        exp_pop  = acc ? (4'b0001 << id) : 4'b0000;
      end
      #1;
      check("rnd.id_ready", id_ready, exp_idr);
      check("rnd.pop", pop, exp_pop);
      check("rnd.valid_out", valid_out, exp_v);
      check("rnd.drop", drop, exp_drop);
      if (exp_v) begin
        check("rnd.data_out", data_out, pend[0].data);
        check("rnd.class_out", class_out, pend[0].cls);
      end
      if (reset) begin
        if (exp_v && ready_in) void'(pend.pop_front());
        if (acc) pend.push_back('{cls: id, data: 6'h00, avail: t + 2});
        drop_m = id_valid && exp_idr && empty[id];
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_pop_dispatch.md
Name: fifo_pop_dispatch

Overview:
- Downstream stage of the round-robin arbiter.
- Takes each granted queue id, pops that queue from the 4-entry input FIFO bank, and captures the word the FIFO returns one cycle later.
- Tags each word with its source class and presents it to the egress stage through a valid/ready handshake, preserving grant order.

Parameters:
- DATA_W, 6, width of one FIFO word.
- NUM_Q, 4, number of queues. Fixed at 4; id is 2 bits.
- OUT_DEPTH, 3, entries in the output buffer. Must be at least 3 for one word per cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- id  in  2  granted queue index from the arbiter.
- id_valid  in  1  id is a valid grant this cycle.
- id_ready  out  1  block accepts a grant this cycle.
- empty  in  4  per-queue empty flags from the FIFO bank.
- pop  out  4  one-hot pop strobe to the FIFO bank.
- fifo_data  in  4*DATA_W  packed read data; queue q occupies bits [q*DATA_W +: DATA_W].
- data_out  out  DATA_W  dispatched word.
- class_out  out  2  source queue of data_out.
- valid_out  out  1  data_out/class_out valid.
- ready_in  in  1  egress accepts the word.
- drop  out  1  one-cycle pulse: grant to an empty queue was discarded.

Behaviour:
- Reset (reset=0, asynchronous):
  - pop=0, valid_out=0, drop=0, data_out=0, class_out=0.
  - Output buffer and in-flight register are cleared.
  - id_ready=0 while reset=0.
  - Any reset assertion mid-operation discards buffered and in-flight words; no partial pop survives.
- Credit counter cnt (0..OUT_DEPTH), registered, counts in-flight plus buffered words.
  - id_ready = (cnt < OUT_DEPTH).
  - No combinational path exists from ready_in to id_ready.
- Accept, cycle N: accept = id_valid & id_ready & ~empty[id].
  - pop[id]=1 combinationally in cycle N; all other pop bits 0.
  - pop is gated by reset.
- Empty grant, cycle N: id_valid & id_ready & empty[id].
  - Grant is consumed with no pop and no cnt change.
  - drop is registered high in cycle N+1 for one cycle.
- In-flight register: on accept, records {valid, id} at the end of cycle N.
- Cycle N+1: the FIFO presents the word on fifo_data[id]. The block muxes that slice and writes {id, word} into the output buffer at the end of N+1.
- Cycle N+2: the word is at the buffer head; valid_out=1 if it is the oldest entry.
  - Latency from grant to valid_out is 2 cycles.
- Output handshake:
  - Head is removed when valid_out & ready_in.
  - data_out/class_out hold stable while valid_out=1 and ready_in=0.
- cnt update:
  - +1 on accept.
  - -1 on a valid_out & ready_in transfer.
  - Both in the same cycle: cnt unchanged.
- Throughput: with OUT_DEPTH=3 and ready_in held high, one word per cycle is sustained.
- Boundaries:
  - cnt=OUT_DEPTH: id_ready=0, so grants are not taken and pop=0, even if id_valid=1.
  - Buffer empty with a word arriving: valid_out rises exactly 2 cycles after the accept; there is no bypass.
  - Buffer pointers wrap modulo OUT_DEPTH.
  - empty[id] changing in the same cycle as the grant: the sampled value in cycle N decides.
  - id is ignored when id_valid=0.

Decomposition:
- Shared package holds:
  - NUM_Q=4, ID_W=2, DATA_W default.
  - A typedef for the tagged word {class[1:0], data[DATA_W-1:0]}.
- One sub-module, pop_out_buf: OUT_DEPTH-entry synchronous FIFO with push, pop, head data, full and empty outputs, and the same asynchronous active-low reset.
- The top level contains the pop decode, the in-flight register, the read mux, the credit counter and the drop logic.

Test Plan:
- Single grant: id=2, id_valid=1 for one cycle, empty=0000, fifo_data slice 2=6'h2A, ready_in=1.
  -> pop=0100 in cycle 0; valid_out=1, data_out=2A, class_out=2 in cycle 2; valid_out=0 in cycle 3.
- Round-robin stream: ids 0,1,2,3 on consecutive cycles, ready_in=1, slice q returns 6'h10+q.
  -> outputs 10,11,12,13 with class 0..3 on cycles 2..5; id_ready stays 1 throughout.
- Backpressure: ready_in=0 and grants offered every cycle.
  -> exactly 3 pops, then id_ready=0 and pop=0. After ready_in=1, the three words drain in order and id_ready returns 1 on the cycle after the first transfer.
- Empty grant: empty=0010, id=1, id_valid=1.
  -> pop=0000, drop=1 for one cycle next cycle, cnt unchanged, no valid_out.
- Simultaneous push and pop: cnt=3 with ready_in=1 sustained, and a grant accepted once id_ready rises.
  -> cnt does not exceed 3, no word is lost or duplicated, and order is preserved.
- Reset mid-stream: reset=0 asynchronously with 2 words buffered and 1 in flight.
  -> valid_out, pop and id_ready go to 0 immediately. After release, the first grant produces output 2 cycles later and no stale word appears.
